// File: rtl/bldc_motor_supervisor.sv
// BLDC drive supervisor: ramped duty, brake-before-reverse, and hall-code fault latching.
// Optional stall watchdog is compiled in with macro BLDC_STALL_DETECT_EN.
module bldc_motor_supervisor #(
    parameter int DUTY_WIDTH       = 9,
    parameter int MAX_DUTY_CYCLE   = 'h1FF,
    parameter int RAMP_STEP        = 1,
    parameter int RAMP_DIV         = 256,
    parameter int BRAKE_CYCLES     = 1024,
    parameter int STALL_TIMEOUT    = 'h3FFFF,
    parameter int STALL_DUTY       = 'h080,
    parameter int HALL_COUNT_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [DUTY_WIDTH:0]         duty_cmd,
    input  logic [2:0]                  hall,
    input  logic                        fault_clr,
    input  logic                        hall_count_clr,
    output logic [DUTY_WIDTH-1:0]       duty_out,
    output logic                        dir_out,
    output logic                        drive_en,
    output logic                        brake,
    output logic                        fault,
    output logic [HALL_COUNT_WIDTH-1:0] hall_count,
    output logic [1:0]                  state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2, FAULT = 2'd3} state_t;

    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam int BRK_W = $clog2(BRAKE_CYCLES + 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [BRK_W-1:0]      BRK_LAST = BRK_W'(BRAKE_CYCLES - 1);
    localparam logic [DUTY_WIDTH-1:0] MAX_C    = DUTY_WIDTH'(MAX_DUTY_CYCLE);
    localparam logic [DUTY_WIDTH-1:0] STEP_C   = DUTY_WIDTH'(RAMP_STEP);

    state_t                      state_q, state_d;
    logic [DUTY_WIDTH-1:0]       duty_q, duty_d;
    logic                        dir_q, dir_d;
    logic                        fault_q, fault_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [BRK_W-1:0]            brk_q, brk_d;
    logic [HALL_COUNT_WIDTH-1:0] hall_count_q, hall_count_d;
    logic [2:0]                  hall_s1_q, hall_s2_q, hall_prev_q;
    logic                        inv_q, inv_d;

    logic                  hall_bad, prev_bad, hall_edge, stall_hit, cmd_dir;
    logic [DUTY_WIDTH-1:0] mag, target, diff, ramp_next;

    assign hall_bad  = (hall_s2_q == 3'b000) || (hall_s2_q == 3'b111);
    assign prev_bad  = (hall_prev_q == 3'b000) || (hall_prev_q == 3'b111);
    assign hall_edge = (hall_s2_q != hall_prev_q) && !hall_bad && !prev_bad;
    assign inv_d     = (state_q == RUN) && hall_bad;
    assign mag       = duty_cmd[DUTY_WIDTH-1:0];
    assign cmd_dir   = duty_cmd[DUTY_WIDTH];
    // A reversal request ramps down to zero first, then brakes.
    assign target    = (cmd_dir == dir_q) ? ((mag > MAX_C) ? MAX_C : mag) : '0;

`ifdef BLDC_STALL_DETECT_EN
    localparam int STL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [STL_W-1:0]      STL_LAST = STL_W'(STALL_TIMEOUT - 1);
    localparam logic [DUTY_WIDTH-1:0] STALL_C  = DUTY_WIDTH'(STALL_DUTY);
    logic [STL_W-1:0] stall_q, stall_d;
    logic             stall_armed;

    assign stall_armed = (state_q == RUN) && (duty_q >= STALL_C) && !hall_edge;
    assign stall_hit   = stall_armed && (stall_q == STL_LAST);
    assign stall_d     = stall_armed ? stall_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        ramp_next = duty_q;
        diff      = '0;
        if (target > duty_q) begin
            diff      = target - duty_q;
            ramp_next = duty_q + ((diff > STEP_C) ? STEP_C : diff);
        end else if (target < duty_q) begin
            diff      = duty_q - target;
            ramp_next = duty_q - ((diff > STEP_C) ? STEP_C : diff);
        end
    end

    always_comb begin
        hall_count_d = hall_count_q;
        if (hall_count_clr)  hall_count_d = '0;
        else if (hall_edge)  hall_count_d = hall_count_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        div_d   = div_q;
        brk_d   = brk_q;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (en && (mag != '0)) begin
                    state_d = RUN;
                    dir_d   = cmd_dir;
                    div_d   = '0;
                end
            end
            RUN: begin
                if ((hall_bad && inv_q) || stall_hit) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    duty_d  = '0;
                end else if (!en) begin
                    state_d = IDLE;
                    duty_d  = '0;
                end else if ((duty_q == '0) && (cmd_dir != dir_q)) begin
                    state_d = BRAKE;
                    brk_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    duty_d = ramp_next;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            BRAKE: begin
                duty_d = '0;
                if (!en) begin
                    state_d = IDLE;
                end else if (brk_q == BRK_LAST) begin
                    state_d = RUN;
                    dir_d   = ~dir_q;
                    div_d   = '0;
                end else begin
                    brk_d = brk_q + 1'b1;
                end
            end
            FAULT: begin
                duty_d  = '0;
                fault_d = 1'b1;
                if (fault_clr && !en) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            dir_q        <= 1'b0;
            fault_q      <= 1'b0;
            div_q        <= '0;
            brk_q        <= '0;
            hall_count_q <= '0;
            hall_s1_q    <= 3'b000;
            hall_s2_q    <= 3'b000;
            hall_prev_q  <= 3'b000;
            inv_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            dir_q        <= dir_d;
            fault_q      <= fault_d;
            div_q        <= div_d;
            brk_q        <= brk_d;
            hall_count_q <= hall_count_d;
            hall_s1_q    <= hall;
            hall_s2_q    <= hall_s1_q;
            hall_prev_q  <= hall_s2_q;
            inv_q        <= inv_d;
        end
    end

    assign duty_out   = duty_q;
    assign dir_out    = dir_q;
    assign drive_en   = (state_q == RUN);
    assign brake      = (state_q == BRAKE);
    assign fault      = fault_q;
    assign hall_count = hall_count_q;
    assign state      = state_q;
endmodule

// File: tb/tb_bldc_motor_supervisor.sv
// Randomized-stimulus bench for bldc_motor_supervisor against a cycle-level behavioural model.
// Honours BLDC_STALL_DETECT_EN so the same bench covers both builds.
module tb_bldc_motor_supervisor;
    localparam int DW    = 9;
    localparam int HCW   = 7;
    localparam int RDIV  = 4;
    localparam int RSTEP = 1;
    localparam int BRK   = 8;
    localparam int STO   = 64;
    localparam int SDUTY = 2;
    localparam int MAXD  = 'h1FF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [DW:0]   duty_cmd = '0;
    logic [2:0]    hall = 3'b001;
    logic          fault_clr = 1'b0;
    logic          hall_count_clr = 1'b0;
    logic [DW-1:0] duty_out;
    logic          dir_out, drive_en, brake, fault;
    logic [HCW-1:0] hall_count;
    logic [1:0]    state;

    always #5 clk = ~clk;

    bldc_motor_supervisor #(
        .DUTY_WIDTH(DW), .MAX_DUTY_CYCLE(MAXD), .RAMP_STEP(RSTEP), .RAMP_DIV(RDIV),
        .BRAKE_CYCLES(BRK), .STALL_TIMEOUT(STO), .STALL_DUTY(SDUTY), .HALL_COUNT_WIDTH(HCW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .duty_cmd(duty_cmd), .hall(hall),
        .fault_clr(fault_clr), .hall_count_clr(hall_count_clr), .duty_out(duty_out),
        .dir_out(dir_out), .drive_en(drive_en), .brake(brake), .fault(fault),
        .hall_count(hall_count), .state(state)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: state codes 0..3 = IDLE/RUN/BRAKE/FAULT
    int m_state, m_duty, m_dir, m_fault, m_cnt, m_runc, m_brk, m_stall, m_prev;
    bit m_bad;
    int m_sync[$];
    int seq[6] = '{1, 3, 2, 6, 4, 5};
    int hidx = 0;
    bit rot = 1'b0;

    function automatic bit valid_code(int c);
        return (c != 0) && (c != 7);
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_duty = 0; m_dir = 0; m_fault = 0; m_cnt = 0;
        m_runc = 0; m_brk = 0; m_stall = 0; m_prev = 0; m_bad = 1'b0;
        m_sync = '{0, 0};
    endtask

    task automatic model_clock();
        int sync, mag, cdir, tgt;
        bit edge_seen, bad_now, run, stall_flt;
        sync      = m_sync[0];
        edge_seen = (sync != m_prev) && valid_code(sync) && valid_code(m_prev);
        bad_now   = !valid_code(sync);
        mag       = int'(duty_cmd[DW-1:0]);
        cdir      = int'(duty_cmd[DW]);
        run       = (m_state == 1);
        stall_flt = 1'b0;
`ifdef BLDC_STALL_DETECT_EN
        if (run && m_duty >= SDUTY && !edge_seen) begin
            m_stall++;
            stall_flt = (m_stall >= STO);
        end else begin
            m_stall = 0;
        end
`endif
        case (m_state)
            0: begin
                m_duty = 0;
                if (en && mag != 0) begin m_state = 1; m_dir = cdir; m_runc = 0; end
            end
            1: begin
                if ((bad_now && m_bad) || stall_flt) begin
                    m_state = 3; m_fault = 1; m_duty = 0;
                end else if (!en) begin
                    m_state = 0; m_duty = 0;
                end else if (m_duty == 0 && cdir != m_dir) begin
                    m_state = 2; m_brk = 0;
                end else begin
                    m_runc++;
                    if (m_runc % RDIV == 0) begin
                        tgt = (cdir == m_dir) ? imin(mag, MAXD) : 0;
                        if (tgt > m_duty) m_duty += imin(RSTEP, tgt - m_duty);
                        else              m_duty -= imin(RSTEP, m_duty - tgt);
                    end
                end
            end
            2: begin
                m_duty = 0;
                m_brk++;
                if (!en) m_state = 0;
                else if (m_brk == BRK) begin m_state = 1; m_dir ^= 1; m_runc = 0; end
            end
            default: begin
                if (fault_clr && !en) begin m_state = 0; m_fault = 0; end
            end
        endcase
        m_bad = run && bad_now;
        if (hall_count_clr) m_cnt = 0;
        else if (edge_seen) m_cnt = (m_cnt + 1) % (1 << HCW);
        m_prev = sync;
        void'(m_sync.pop_front());
        m_sync.push_back(int'(hall));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("duty_out",   32'(duty_out),   m_duty);
        check("dir_out",    32'(dir_out),    m_dir);
        check("drive_en",   32'(drive_en),   (m_state == 1) ? 1 : 0);
        check("brake",      32'(brake),      (m_state == 2) ? 1 : 0);
        check("fault",      32'(fault),      m_fault);
        check("hall_count", 32'(hall_count), m_cnt);
        check("state",      32'(state),      m_state);
    endtask

    task automatic adv_hall();
        hidx = (hidx + 1) % 6;
        hall = 3'(seq[hidx]);
    endtask

    task automatic step();
        if (rot && $urandom_range(0, 2) == 0) adv_hall();
        @(posedge clk);
        if (reset) model_reset();
        else       model_clock();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nb, hit;
        int dq[$];
        int exp_ramp[6] = '{2, 1, 0, 1, 2, 3};
        int last;

        model_reset();
        #2 reset = 1'b1;
        steps(3);
        reset = 1'b0;
        steps(2);

        // Ramp up to 3 in direction 0 with a rotating hall
        rot = 1'b1;
        en = 1'b1; duty_cmd = 10'h003;
        steps(30);
        check("rampA_duty", 32'(duty_out), 3);

        // Reversal: ramp down, brake, ramp back up
        duty_cmd = 10'h203;
        nb = 0; last = 3;
        for (int i = 0; i < 60; i++) begin
            step();
            if (brake === 1'b1) nb++;
            if (int'(duty_out) != last) begin last = int'(duty_out); dq.push_back(last); end
        end
        check("brake_len", nb, BRK);
        check("rev_dir", 32'(dir_out), 1);
        check("ramp_len", dq.size(), 6);
        for (int i = 0; i < 6 && i < dq.size(); i++) check("ramp_seq", dq[i], exp_ramp[i]);

        // Randomized operation with occasional single-cycle hall glitches
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                duty_cmd = {1'($urandom_range(0, 1)), 9'($urandom_range(0, 6))};
            en             = ($urandom_range(0, 39) != 0);
            hall_count_clr = ($urandom_range(0, 29) == 0);
            fault_clr      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rot = 1'b0; hall = 3'b000; step();
                hall = 3'(seq[hidx]); step(); rot = 1'b1;
            end else begin
                step();
            end
        end
        hall_count_clr = 1'b0;

        // Invalid hall held for two cycles while running
        en = 1'b0; fault_clr = 1'b1; steps(3); fault_clr = 1'b0;
        en = 1'b1; duty_cmd = 10'h003; steps(10);
        check("pre_fault_state", 32'(state), 1);
        rot = 1'b0; hall = 3'b000; steps(4);
        check("fault_set", 32'(fault), 1);
        check("fault_state", 32'(state), 3);
        hall = 3'(seq[hidx]);
        fault_clr = 1'b1; step();
        check("fault_hold_en", 32'(state), 3);
        en = 1'b0; step();
        check("fault_exit", 32'(state), 0);
        check("fault_clr", 32'(fault), 0);
        fault_clr = 1'b0;

        // Frozen but valid hall at duty 3
        rot = 1'b1; en = 1'b1; duty_cmd = 10'h003; steps(25);
        rot = 1'b0; hidx = 5; hall = 3'b101; steps(90);
`ifdef BLDC_STALL_DETECT_EN
        check("stall_fault", 32'(fault), 1);
`else
        check("stall_fault", 32'(fault), 0);
`endif
        en = 1'b0; fault_clr = 1'b1; steps(2); fault_clr = 1'b0;

        // Asynchronous reset in the middle of a ramp
        rot = 1'b1; en = 1'b1; duty_cmd = 10'h005;
        hit = 0;
        for (int i = 0; i < 80 && hit == 0; i++) begin
            step();
            if (duty_out == 9'd5) hit = 1;
        end
        check("reach_duty5", hit, 1);
        reset = 1'b1; #2;
        check("arst_duty", 32'(duty_out), 0);
        check("arst_state", 32'(state), 0);
        check("arst_drive", 32'(drive_en), 0);
        check("arst_dir", 32'(dir_out), 0);
        check("arst_cnt", 32'(hall_count), 0);
        model_reset();
        en = 1'b0; rot = 1'b0;
        steps(2);
        reset = 1'b0;

        // Hall counter wrap and clear-wins-over-edge
        hall_count_clr = 1'b1; step(); hall_count_clr = 1'b0;
        steps(3);
        for (int i = 0; i < 127; i++) begin adv_hall(); step(); end
        steps(4);
        check("cnt_max", 32'(hall_count), 127);
        adv_hall(); steps(4);
        check("cnt_wrap", 32'(hall_count), 0);
        adv_hall(); steps(4);
        check("cnt_one", 32'(hall_count), 1);
        adv_hall(); steps(2);
        hall_count_clr = 1'b1; step(); hall_count_clr = 1'b0;
        steps(2);
        check("cnt_clr_edge", 32'(hall_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
